mdll_sel_sequencer: RTL and testbench

- Registered, parametrised successor to the delay-line source-select logic of the FMDLL.
- Runs on the DLL output clock and drives the 2-bit delay-line mux select over a programmable superframe of M frames × N cycles.
- Per frame: one reference injection, alignment slot or recirculation slot; recirculation for the rest of the frame.
- Adds features the previous generation lacks: shadowed, glitch-free reconfiguration at superframe boundaries; free-run mode; graceful enable/disable; illegal-config flagging.

---
 rtl/mdll_sel_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_mdll_sel_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdll_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mdll_sel_sequencer
//
// Purpose:
//   This block drives the 2-bit delay-line source select of the MDLL. It runs
//   on the DLL output clock.
//
//   The timing is organised as superframes. Each superframe holds M frames, and
//   each frame is N cycles long.
//     - Every frame opens with one slot cycle. The slot is either a reference
//       injection (INJECT) or an alignment/hold slot (ALIGN).
//     - The remaining cycles of the frame recirculate (RUN).
//
//   Configuration (N, M, mode) is double-buffered. New values only take effect
//   in IDLE or on the last cycle of a superframe, so a reconfiguration can never
//   glitch a frame in progress.
//
// Ports:
//   clk          DLL output clock (single clock domain)
//   rst          synchronous reset, active-high
//   en           sequencer enable; dropping it lets the current superframe
//                finish before returning to IDLE
//   ref_edge     one-cycle reference pulse, already synchronised to clk
//   mode         0 = inject every superframe, 1 = free-run after first inject
//   cfg_n        requested N (1..2^NW-1)
//   cfg_m        requested M (1..2^MW-1)
//   cfg_load     pulse: capture cfg_n/cfg_m/mode into the pending registers
//   sel          delay-line mux select
//   frame_start  first cycle of every frame
//   super_start  first cycle of every superframe
//   n_cnt        cycle index within the frame
//   m_cnt        frame index within the superframe
//   active       sequencer is not IDLE
//   cfg_pend     a loaded config is waiting for the next boundary
//   cfg_err      sticky flag: a zero N or M was loaded
// -----------------------------------------------------------------------------
module mdll_sel_sequencer #(
    parameter int          NW      = 4,
    parameter int          MW      = 2,
    parameter logic [1:0]  SEL_INJ = 2'b00,
    parameter logic [1:0]  SEL_REC = 2'b01,
    parameter logic [1:0]  SEL_ALN = 2'b10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          ref_edge,
    input  logic          mode,
    input  logic [NW-1:0] cfg_n,
    input  logic [MW-1:0] cfg_m,
    input  logic          cfg_load,
    output logic [1:0]    sel,
    output logic          frame_start,
    output logic          super_start,
    output logic [NW-1:0] n_cnt,
    output logic [MW-1:0] m_cnt,
    output logic          active,
    output logic          cfg_pend,
    output logic          cfg_err
);

    localparam logic [NW-1:0] N_ONE = NW'(1);
    localparam logic [MW-1:0] M_ONE = MW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INJECT = 2'd1,
        ST_ALIGN  = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] n_cnt_q, n_cnt_d;
    logic [MW-1:0] m_cnt_q, m_cnt_d;

    // Active (in use) and pending (loaded, not yet applied) configuration
    logic [NW-1:0] act_n_q, act_n_d, pend_n_q, pend_n_d;
    logic [MW-1:0] act_m_q, act_m_d, pend_m_q, pend_m_d;
    logic          act_mode_q, act_mode_d, pend_mode_q, pend_mode_d;
    logic          cfg_pend_q, cfg_pend_d;
    logic          cfg_err_q, cfg_err_d;

    // Registered outputs
    logic [1:0]    sel_q, sel_d;
    logic          frame_start_q, frame_start_d;
    logic          super_start_q, super_start_d;
    logic          active_q, active_d;

    logic [NW-1:0] load_n;
    logic [MW-1:0] load_m;
    logic          load_zero;
    logic          frame_end;
    logic          super_end;
    logic          copy_en;
    logic [NW-1:0] new_n;
    logic [MW-1:0] new_m;
    logic          new_mode;

    // A zero field is flagged as an error and then stored as 1. This keeps
    // the N-1 / M-1 terminal counts meaningful.
    assign load_zero = (cfg_n == '0) || (cfg_m == '0);
    assign load_n    = (cfg_n == '0) ? N_ONE : cfg_n;
    assign load_m    = (cfg_m == '0) ? M_ONE : cfg_m;

    // A frame ends when n_cnt reaches N-1. With N = 1, the slot cycle
    // itself is the last cycle of the frame.
    assign frame_end = (state_q != ST_IDLE) && (n_cnt_q == act_n_q - N_ONE);
    assign super_end = frame_end && (m_cnt_q == act_m_q - M_ONE);
    assign copy_en   = (state_q == ST_IDLE) || super_end;

    // When a cfg_load coincides with the copy, the freshly loaded values
    // bypass the pending registers and are applied directly.
    assign new_n    = cfg_load ? load_n : pend_n_q;
    assign new_m    = cfg_load ? load_m : pend_m_q;
    assign new_mode = cfg_load ? mode   : pend_mode_q;

    // ---------------------------------------------------------------- config
    always_comb begin
        pend_n_d    = pend_n_q;
        pend_m_d    = pend_m_q;
        pend_mode_d = pend_mode_q;
        act_n_d     = act_n_q;
        act_m_d     = act_m_q;
        act_mode_d  = act_mode_q;
        cfg_err_d   = cfg_err_q;
        cfg_pend_d  = cfg_pend_q | cfg_load;

        if (cfg_load) begin
            pend_n_d    = load_n;
            pend_m_d    = load_m;
            pend_mode_d = mode;
            cfg_err_d   = load_zero;
        end

        if (copy_en) begin
            act_n_d    = new_n;
            act_m_d    = new_m;
            act_mode_d = new_mode;
            cfg_pend_d = 1'b0;
        end
    end

    // ----------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_cnt_q     <= '0;
            m_cnt_q     <= '0;
            act_n_q     <= N_ONE;
            act_m_q     <= M_ONE;
            act_mode_q  <= 1'b0;
            pend_n_q    <= N_ONE;
            pend_m_q    <= M_ONE;
            pend_mode_q <= 1'b0;
            cfg_pend_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            sel_q         <= SEL_REC;
            frame_start_q <= 1'b0;
            super_start_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_cnt_q     <= n_cnt_d;
            m_cnt_q     <= m_cnt_d;
            act_n_q     <= act_n_d;
            act_m_q     <= act_m_d;
            act_mode_q  <= act_mode_d;
            pend_n_q    <= pend_n_d;
            pend_m_q    <= pend_m_d;
            pend_mode_q <= pend_mode_d;
            cfg_pend_q  <= cfg_pend_d;
            cfg_err_q   <= cfg_err_d;
            sel_q         <= sel_d;
            frame_start_q <= frame_start_d;
            super_start_q <= super_start_d;
            active_q      <= active_d;
        end
    end

    // ----------------------------------------------------- next-state logic
    always_comb begin
        state_d = state_q;
        n_cnt_d = n_cnt_q;
        m_cnt_d = m_cnt_q;

        if (state_q == ST_IDLE) begin
            n_cnt_d = '0;
            m_cnt_d = '0;
            if (en && ref_edge) begin
                state_d = ST_INJECT;
            end
        end else if (frame_end) begin
            n_cnt_d = '0;
            if (!super_end) begin
                m_cnt_d = m_cnt_q + M_ONE;
                state_d = ST_ALIGN;
            end else begin
                // The next superframe starts under the config applied at
                // this boundary, including its mode.
                m_cnt_d = '0;
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (new_mode) begin
                    state_d = ST_ALIGN;
                end else begin
                    state_d = ST_INJECT;
                end
            end
        end else begin
            state_d = ST_RUN;
            n_cnt_d = n_cnt_q + N_ONE;
        end
    end

    // ------------------------------------------------------- output logic
    // Outputs are decoded from the next state and then registered, so they
    // line up with state_q.
    always_comb begin
        sel_d         = SEL_REC;
        frame_start_d = 1'b0;
        super_start_d = 1'b0;
        active_d      = (state_d != ST_IDLE);

        case (state_d)
            ST_INJECT: begin
                sel_d         = SEL_INJ;
                frame_start_d = 1'b1;
                super_start_d = 1'b1;
            end
            ST_ALIGN: begin
                sel_d         = SEL_ALN;
                frame_start_d = 1'b1;
                // ALIGN at frame 0 only occurs as a free-run superframe start
                super_start_d = (m_cnt_d == '0);
            end
            default: begin
                sel_d = SEL_REC;
            end
        endcase
    end

    assign sel         = sel_q;
    assign frame_start = frame_start_q;
    assign super_start = super_start_q;
    assign n_cnt       = n_cnt_q;
    assign m_cnt       = m_cnt_q;
    assign active      = active_q;
    assign cfg_pend    = cfg_pend_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_mdll_sel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdll_sel_sequencer
//
// Directed vector table for mdll_sel_sequencer, plus a hand-written
// superframe-length check at maximum N.
//
// Vector timing:
//   - Each vector's inputs are driven on the falling edge.
//   - The outputs are sampled 1 ns after the following rising edge.
//   - The sampled outputs are compared against the vector's expected fields.
// -----------------------------------------------------------------------------
module tb_mdll_sel_sequencer;

    localparam int NW = 4;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          ref_edge = 1'b0;
    logic          mode = 1'b0;
    logic [NW-1:0] cfg_n = '0;
    logic [MW-1:0] cfg_m = '0;
    logic          cfg_load = 1'b0;
    logic [1:0]    sel;
    logic          frame_start;
    logic          super_start;
    logic [NW-1:0] n_cnt;
    logic [MW-1:0] m_cnt;
    logic          active;
    logic          cfg_pend;
    logic          cfg_err;

    always #5 clk = ~clk;

    mdll_sel_sequencer #(.NW(NW), .MW(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ref_edge    (ref_edge),
        .mode        (mode),
        .cfg_n       (cfg_n),
        .cfg_m       (cfg_m),
        .cfg_load    (cfg_load),
        .sel         (sel),
        .frame_start (frame_start),
        .super_start (super_start),
        .n_cnt       (n_cnt),
        .m_cnt       (m_cnt),
        .active      (active),
        .cfg_pend    (cfg_pend),
        .cfg_err     (cfg_err)
    );

    typedef struct {
        logic          rst;
        logic          en;
        logic          ref_edge;
        logic          mode;
        logic [NW-1:0] cfg_n;
        logic [MW-1:0] cfg_m;
        logic          cfg_load;
        logic [1:0]    sel;
        logic          fs;
        logic          ss;
        logic [NW-1:0] n;
        logic [MW-1:0] m;
        logic          act;
        logic          pend;
        logic          err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic void add(input logic r, input logic e, input logic rf,
                                input logic md, input int cn, input int cm,
                                input logic ld, input int s, input logic fs,
                                input logic ss, input int n, input int m,
                                input logic act, input logic pend, input logic err);
        vec_t v;
        v.rst = r;
        v.en = e;
        v.ref_edge = rf;
        v.mode = md;
        v.cfg_n = NW'(cn);
        v.cfg_m = MW'(cm);
        v.cfg_load = ld;
        v.sel = 2'(s);
        v.fs = fs;
        v.ss = ss;
        v.n = NW'(n);
        v.m = MW'(m);
        v.act = act;
        v.pend = pend;
        v.err = err;
        vecs.push_back(v);
    endfunction

    initial begin
        // Arguments to add():
        //   inputs:   rst en ref mode cfg_n cfg_m load
        //   expected: sel fs ss n m act pend err
        // Sel codes: 0 = inject, 1 = recirculate, 2 = align.

        // --- N=4 M=1 mode 0 ---
        add(1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0);   // reset state
        add(0,0,0,0,4,1,1, 1,0,0,0,0,0,0,0);   // load in IDLE: applied at once
        add(0,1,1,0,0,0,0, 0,1,1,0,0,1,0,0);   // ref_edge -> INJECT
        add(0,1,0,0,0,0,0, 1,0,0,1,0,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,2,0,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,3,0,1,0,0);
        add(0,1,0,0,0,0,0, 0,1,1,0,0,1,0,0);   // inject every frame
        add(0,1,0,0,0,0,0, 1,0,0,1,0,1,0,0);

        // --- N=3 M=3 mode 0, ref_edge ignored while running ---
        add(1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0);
        add(0,0,0,0,3,3,1, 1,0,0,0,0,0,0,0);
        add(0,1,1,0,0,0,0, 0,1,1,0,0,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,0,1,0,0);
        add(0,1,1,0,0,0,0, 1,0,0,2,0,1,0,0);
        add(0,1,0,0,0,0,0, 2,1,0,0,1,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,1,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,2,1,1,0,0);
        add(0,1,1,0,0,0,0, 2,1,0,0,2,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,2,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,2,2,1,0,0);
        add(0,1,0,0,0,0,0, 0,1,1,0,0,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,0,1,0,0);

        // --- N=3 M=2, reload to N=2 mid-superframe ---
        add(1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0);
        add(0,0,0,0,3,2,1, 1,0,0,0,0,0,0,0);
        add(0,1,1,0,0,0,0, 0,1,1,0,0,1,0,0);
        add(0,1,0,0,2,2,1, 1,0,0,1,0,1,1,0);   // pending set, old pattern continues
        add(0,1,0,0,0,0,0, 1,0,0,2,0,1,1,0);
        add(0,1,0,0,0,0,0, 2,1,0,0,1,1,1,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,1,1,1,0);
        add(0,1,0,0,0,0,0, 1,0,0,2,1,1,1,0);
        add(0,1,0,0,0,0,0, 0,1,1,0,0,1,0,0);   // boundary: applied, pend clears
        add(0,1,0,0,0,0,0, 1,0,0,1,0,1,0,0);
        add(0,1,0,0,0,0,0, 2,1,0,0,1,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,1,1,0,0);
        add(0,1,0,0,0,0,0, 0,1,1,0,0,1,0,0);

        // --- free-run mode N=2 M=2 ---
        add(1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0);
        add(0,0,0,1,2,2,1, 1,0,0,0,0,0,0,0);
        add(0,1,1,0,0,0,0, 0,1,1,0,0,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,0,1,0,0);
        add(0,1,0,0,0,0,0, 2,1,0,0,1,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,1,1,0,0);
        add(0,1,0,0,0,0,0, 2,1,1,0,0,1,0,0);   // superframe start via ALIGN
        add(0,1,1,0,0,0,0, 1,0,0,1,0,1,0,0);
        add(0,1,0,0,0,0,0, 2,1,0,0,1,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,1,1,0,0);
        add(0,1,0,0,0,0,0, 2,1,1,0,0,1,0,0);

        // --- illegal config, then a legal load coinciding with the boundary ---
        add(1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,1, 1,0,0,0,0,0,0,1);
        add(0,1,1,0,0,0,0, 0,1,1,0,0,1,0,1);
        add(0,1,0,0,0,0,0, 0,1,1,0,0,1,0,1);   // N=M=1: inject every cycle
        add(0,1,0,0,0,0,0, 0,1,1,0,0,1,0,1);
        add(0,1,0,0,2,1,1, 0,1,1,0,0,1,0,0);   // load wins, pend=0, err clears
        add(0,1,0,0,0,0,0, 1,0,0,1,0,1,0,0);
        add(0,1,0,0,0,0,0, 0,1,1,0,0,1,0,0);

        // --- graceful disable, then reset mid-RUN ---
        add(1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0);
        add(0,0,0,0,2,3,1, 1,0,0,0,0,0,0,0);
        add(0,1,1,0,0,0,0, 0,1,1,0,0,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,0,1,0,0);
        add(0,1,0,0,0,0,0, 2,1,0,0,1,1,0,0);
        add(0,0,0,0,0,0,0, 1,0,0,1,1,1,0,0);   // en dropped at m_cnt=1
        add(0,0,0,0,0,0,0, 2,1,0,0,2,1,0,0);
        add(0,0,0,0,0,0,0, 1,0,0,1,2,1,0,0);
        add(0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0);   // superframe done -> IDLE
        add(0,0,1,0,0,0,0, 1,0,0,0,0,0,0,0);   // ref without en ignored
        add(0,1,1,0,0,0,0, 0,1,1,0,0,1,0,0);
        add(0,1,0,0,0,0,0, 1,0,0,1,0,1,0,0);
        add(1,1,0,0,0,0,0, 1,0,0,0,0,0,0,0);   // reset mid-RUN aborts
        add(0,1,1,0,0,0,0, 0,1,1,0,0,1,0,0);
        add(0,1,0,0,0,0,0, 0,1,1,0,0,1,0,0);   // config back to N=M=1

        foreach (vecs[i]) begin
            logic [14:0] got;
            logic [14:0] exp;
            @(negedge clk);
            rst      = vecs[i].rst;
            en       = vecs[i].en;
            ref_edge = vecs[i].ref_edge;
            mode     = vecs[i].mode;
            cfg_n    = vecs[i].cfg_n;
            cfg_m    = vecs[i].cfg_m;
            cfg_load = vecs[i].cfg_load;
            @(posedge clk);
            #1;
            got = {sel, frame_start, super_start, n_cnt, m_cnt, active, cfg_pend, cfg_err};
            exp = {vecs[i].sel, vecs[i].fs, vecs[i].ss, vecs[i].n, vecs[i].m,
                   vecs[i].act, vecs[i].pend, vecs[i].err};
            n_vec++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got sel=%0d fs=%0b ss=%0b n=%0d m=%0d act=%0b pend=%0b err=%0b, want sel=%0d fs=%0b ss=%0b n=%0d m=%0d act=%0b pend=%0b err=%0b",
                         i, sel, frame_start, super_start, n_cnt, m_cnt, active, cfg_pend, cfg_err,
                         vecs[i].sel, vecs[i].fs, vecs[i].ss, vecs[i].n, vecs[i].m,
                         vecs[i].act, vecs[i].pend, vecs[i].err);
            end else begin
                $display("vec%0d ok: sel=%0d n=%0d m=%0d", i, sel, n_cnt, m_cnt);
            end
        end

        // --- hand sequence: N=15 M=3 superframe is 45 cycles, counters top out ---
        begin
            int cyc;
            int max_n;
            int max_m;
            bit seen;
            @(negedge clk);
            rst = 1'b1;
            en = 1'b0;
            ref_edge = 1'b0;
            cfg_load = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            cfg_n = 4'd15;
            cfg_m = 2'd3;
            mode = 1'b0;
            cfg_load = 1'b1;
            @(negedge clk);
            cfg_load = 1'b0;
            en = 1'b1;
            ref_edge = 1'b1;
            @(posedge clk);
            #1;
            n_vec++;
            if (super_start !== 1'b1 || sel !== 2'b00) begin
                n_fail++;
                $display("FAIL long_start: got ss=%0b sel=%0d, want ss=1 sel=0",
                         super_start, sel);
            end
            @(negedge clk);
            ref_edge = 1'b0;
            cyc = 0;
            max_n = 0;
            max_m = 0;
            seen = 1'b0;
            while (!seen && cyc < 100) begin
                @(posedge clk);
                #1;
                cyc++;
                if (int'(n_cnt) > max_n) max_n = int'(n_cnt);
                if (int'(m_cnt) > max_m) max_m = int'(m_cnt);
                if (super_start === 1'b1) seen = 1'b1;
            end
            n_vec++;
            if (!seen || cyc != 45) begin
                n_fail++;
                $display("FAIL long_period: got %0d cycles (seen=%0b), want 45", cyc, seen);
            end else begin
                $display("long_period ok: %0d cycles", cyc);
            end
            n_vec++;
            if (max_n != 14 || max_m != 2) begin
                n_fail++;
                $display("FAIL long_max: got max n=%0d m=%0d, want n=14 m=2", max_n, max_m);
            end else begin
                $display("long_max ok: n=%0d m=%0d", max_n, max_m);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
